usb_rfifo: RTL and testbench

//  Receive FIFO directly downstream of the packet decoder: deserialises decoded DATA0/1 bits (LSB first) into bytes.

---
 rtl/usb_rfifo_pkg.sv | 23 ++
 rtl/usb_rfifo_if.sv | 29 ++
 rtl/usb_rfifo_ram.sv | 27 ++
 rtl/usb_rfifo.sv | 133 +++++++++++++
 tb/tb_usb_rfifo.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rfifo_pkg.sv
// usb_rfifo_pkg: shared constants and types for the USB receive FIFO.
//   CRC16_BYTES  trailing CRC bytes stripped on commit
//   MAX_PAYLOAD  largest DATA payload; a full-size FIFO needs 2**AW >= MAX_PAYLOAD + CRC16_BYTES
//   pid_t        DATA PID codes seen by the decoder ahead of this FIFO
//   wstate_t     write-side state machine encoding
package usb_rfifo_pkg;

    localparam int CRC16_BYTES = 2;
    localparam int MAX_PAYLOAD = 512;

    typedef enum logic [3:0] {
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111
    } pid_t;

    typedef enum logic {
        WS_IDLE    = 1'b0,
        WS_COLLECT = 1'b1
    } wstate_t;

endpackage

// File: rtl/usb_rfifo_if.sv
// usb_rfifo_if: decoder-side write strobes and application-side read port of the receive FIFO.
//   master: packet decoder / endpoint logic (drives flush0, wr, bit, minuscrc, rd_en)
//   slave : usb_rfifo (drives status flags, count, pkt_done, rd_data, rd_valid, ovf)
interface usb_rfifo_if #(
    parameter int AW = 10
);
    logic          rfifo_flush0;
    logic          rfifo_wr;
    logic          rfifo_bit;
    logic          rfifo_minuscrc;
    logic          rfifo_full;
    logic          rfifo_empty;
    logic [AW:0]   rfifo_count;
    logic          rfifo_pkt_done;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rfifo_ovf;

    modport master (
        output rfifo_flush0, rfifo_wr, rfifo_bit, rfifo_minuscrc, rd_en,
        input  rfifo_full, rfifo_empty, rfifo_count, rfifo_pkt_done, rd_data, rd_valid, rfifo_ovf
    );

    modport slave (
        input  rfifo_flush0, rfifo_wr, rfifo_bit, rfifo_minuscrc, rd_en,
        output rfifo_full, rfifo_empty, rfifo_count, rfifo_pkt_done, rd_data, rd_valid, rfifo_ovf
    );
endinterface

// File: rtl/usb_rfifo_ram.sv
// usb_rfifo_ram: simple dual-port 2**AW x 8 byte store.
//   clk, rst_sync       clock; reset clears only the read register, never the array
//   we, waddr, wdata    synchronous write port
//   re, raddr, rdata    registered read port, data one cycle after re
module usb_rfifo_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_sync,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst_sync)  rdata <= 8'h00;
        else if (re)   rdata <= mem[raddr];
    end
endmodule

// File: rtl/usb_rfifo.sv
// usb_rfifo: store-and-forward receive FIFO behind the USB packet decoder.
//   Deserialises decoded data bits (LSB first) into bytes written speculatively; a good-CRC
//   pulse (rfifo_minuscrc) commits the packet minus its two CRC bytes, anything else rewinds.
//   clk, rst_sync   single clock, synchronous active-high reset
//   bus (slave)     write strobes, read port and status, see usb_rfifo_if
//   Macro USB_RFIFO_OVF_EN: when defined, rfifo_ovf is a sticky flag set by any byte dropped
//   for lack of space; when undefined rfifo_ovf is tied low.
module usb_rfifo
    import usb_rfifo_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic       clk,
    input  logic       rst_sync,
    usb_rfifo_if.slave bus
);
    localparam logic [AW:0] DEPTH_P = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CRC_N   = (AW+1)'(CRC16_BYTES);

    logic [AW:0] wr_ptr, cmt_ptr, rd_ptr;
    // Only the 7 earlier bits are kept; the 8th bit goes straight to the RAM with them.
    logic [6:0]  shreg;
    logic [2:0]  bitcnt;
    logic        pkt_bad, pkt_done, rd_valid;
    wstate_t     ws_q, ws_d;

    logic        full, empty;
    logic [AW:0] pend;
    logic        do_rewind, do_commit, do_shift;
    logic        byte_done, do_store, do_drop, rd_fire;

    assign full  = (wr_ptr - rd_ptr) == DEPTH_P;
    assign empty = cmt_ptr == rd_ptr;
    assign pend  = wr_ptr - cmt_ptr;

    // Write FSM: state register
    always_ff @(posedge clk) begin
        if (rst_sync) ws_q <= WS_IDLE;
        else          ws_q <= ws_d;
    end

    // Write FSM: next state
    always_comb begin
        ws_d = ws_q;
        if (do_rewind || do_commit) ws_d = WS_IDLE;
        else if (do_shift)          ws_d = WS_COLLECT;
    end

    // Write FSM: actions. Flush beats minuscrc beats a data bit; a bit arriving
    // together with minuscrc is ignored.
    always_comb begin
        do_rewind = 1'b0;
        do_commit = 1'b0;
        do_shift  = 1'b0;
        if (!bus.rfifo_flush0) begin
            do_rewind = 1'b1;
        end else if (bus.rfifo_minuscrc) begin
            if (ws_q == WS_COLLECT && bitcnt == 3'd0 && !pkt_bad && pend >= CRC_N)
                do_commit = 1'b1;
            else
                do_rewind = 1'b1;
        end else if (bus.rfifo_wr) begin
            do_shift = 1'b1;
        end
    end

    assign byte_done = do_shift && (bitcnt == 3'd7);
    assign do_store  = byte_done && !full;
    assign do_drop   = byte_done && full;
    assign rd_fire   = bus.rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            pkt_bad  <= 1'b0;
            pkt_done <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            pkt_done <= do_commit;
            rd_valid <= rd_fire;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (do_rewind) begin
                wr_ptr  <= cmt_ptr;
                bitcnt  <= '0;
                pkt_bad <= 1'b0;
            end else if (do_commit) begin
                // CRC bytes were stored speculatively; back them out and publish the rest.
                wr_ptr  <= wr_ptr - CRC_N;
                cmt_ptr <= wr_ptr - CRC_N;
                bitcnt  <= '0;
                pkt_bad <= 1'b0;
            end else if (do_shift) begin
                shreg  <= {bus.rfifo_bit, shreg[6:1]};
                bitcnt <= bitcnt + 3'd1;
                if (do_store) wr_ptr  <= wr_ptr + 1'b1;
                if (do_drop)  pkt_bad <= 1'b1;
            end
        end
    end

    usb_rfifo_ram #(.AW(AW)) u_ram (
        .clk      (clk),
        .rst_sync (rst_sync),
        .we       (do_store),
        .waddr    (wr_ptr[AW-1:0]),
        .wdata    ({bus.rfifo_bit, shreg}),
        .re       (rd_fire),
        .raddr    (rd_ptr[AW-1:0]),
        .rdata    (bus.rd_data)
    );

`ifdef USB_RFIFO_OVF_EN
    logic ovf_q;
    // Sticky until reset; flush and rewind leave it set.
    always_ff @(posedge clk) begin
        if (rst_sync)     ovf_q <= 1'b0;
        else if (do_drop) ovf_q <= 1'b1;
    end
    assign bus.rfifo_ovf = ovf_q;
`else
    assign bus.rfifo_ovf = 1'b0;
`endif

    assign bus.rfifo_full     = full;
    assign bus.rfifo_empty    = empty;
    assign bus.rfifo_count    = cmt_ptr - rd_ptr;
    assign bus.rfifo_pkt_done = pkt_done;
    assign bus.rd_valid       = rd_valid;
endmodule

// File: tb/tb_usb_rfifo.sv
// tb_usb_rfifo: directed self-checking bench for usb_rfifo with a 16-byte FIFO (AW=4).
module tb_usb_rfifo;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_sync = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef USB_RFIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    usb_rfifo_if #(.AW(AW)) bus ();

    usb_rfifo #(.AW(AW)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bus.rfifo_wr  = 1'b1;
            bus.rfifo_bit = b[i];
            tick();
        end
        bus.rfifo_wr = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            bus.rfifo_wr  = 1'b1;
            bus.rfifo_bit = pat[i];
            tick();
        end
        bus.rfifo_wr = 1'b0;
    endtask

    task automatic commit();
        bus.rfifo_minuscrc = 1'b1;
        tick();
        bus.rfifo_minuscrc = 1'b0;
    endtask

    task automatic flush();
        bus.rfifo_flush0 = 1'b0;
        tick();
        bus.rfifo_flush0 = 1'b1;
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        tick();
        tick();
        rst_sync = 1'b0;
        tests++; if (bus.rfifo_empty !== 1'b1)    begin fails++; $display("FAIL reset_empty got %b exp 1", bus.rfifo_empty); end
        tests++; if (bus.rfifo_full !== 1'b0)     begin fails++; $display("FAIL reset_full got %b exp 0", bus.rfifo_full); end
        tests++; if (bus.rfifo_count !== 5'd0)    begin fails++; $display("FAIL reset_count got %0d exp 0", bus.rfifo_count); end
        tests++; if (bus.rfifo_pkt_done !== 1'b0) begin fails++; $display("FAIL reset_pkt_done got %b exp 0", bus.rfifo_pkt_done); end
        tests++; if (bus.rd_valid !== 1'b0)       begin fails++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        tests++; if (bus.rd_data !== 8'h00)       begin fails++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
        tests++; if (bus.rfifo_ovf !== 1'b0)      begin fails++; $display("FAIL reset_ovf got %b exp 0", bus.rfifo_ovf); end
    endtask

    task automatic test_basic();
        logic [2:0][7:0] pay = {8'hFF, 8'h01, 8'hA5};
        for (int i = 0; i < 3; i++) send_byte(pay[i]);
        send_byte(8'h3C);
        send_byte(8'hC3);
        tests++; if (bus.rfifo_count !== 5'd0) begin fails++; $display("FAIL basic_precommit_count got %0d exp 0", bus.rfifo_count); end
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b1) begin fails++; $display("FAIL basic_pkt_done got %b exp 1", bus.rfifo_pkt_done); end
        tests++; if (bus.rfifo_count !== 5'd3)    begin fails++; $display("FAIL basic_count got %0d exp 3", bus.rfifo_count); end
        tick();
        tests++; if (bus.rfifo_pkt_done !== 1'b0) begin fails++; $display("FAIL basic_pkt_done_pulse got %b exp 0", bus.rfifo_pkt_done); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pay[i]) begin fails++; $display("FAIL basic_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, pay[i]); end
        end
        tick();
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL basic_read_empty got v=%b exp 0", bus.rd_valid); end
        bus.rd_en = 1'b0;
        tests++; if (bus.rfifo_empty !== 1'b1 || bus.rfifo_count !== 5'd0) begin fails++; $display("FAIL basic_drained got e=%b c=%0d exp e=1 c=0", bus.rfifo_empty, bus.rfifo_count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i));
        tests++; if (bus.rfifo_count !== 5'd0 || bus.rfifo_empty !== 1'b1) begin fails++; $display("FAIL flush_spec_hidden got c=%0d e=%b exp c=0 e=1", bus.rfifo_count, bus.rfifo_empty); end
        flush();
        tests++; if (bus.rfifo_count !== 5'd0 || bus.rfifo_empty !== 1'b1) begin fails++; $display("FAIL flush_after got c=%0d e=%b exp c=0 e=1", bus.rfifo_count, bus.rfifo_empty); end
        send_byte(8'h12);
        send_byte(8'h34);
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b1) begin fails++; $display("FAIL flush_zero_pkt_done got %b exp 1", bus.rfifo_pkt_done); end
        tests++; if (bus.rfifo_count !== 5'd0 || bus.rfifo_empty !== 1'b1) begin fails++; $display("FAIL flush_zero_count got c=%0d e=%b exp c=0 e=1", bus.rfifo_count, bus.rfifo_empty); end
    endtask

    task automatic test_nonaligned();
        flush();
        send_bits(21, 32'h001F_0F0F);
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b0) begin fails++; $display("FAIL nonaligned_pkt_done got %b exp 0", bus.rfifo_pkt_done); end
        tests++; if (bus.rfifo_count !== 5'd0)    begin fails++; $display("FAIL nonaligned_count got %0d exp 0", bus.rfifo_count); end
        // Leftover bytes or bit phase would corrupt this packet.
        send_byte(8'h5A);
        send_byte(8'hEE);
        send_byte(8'hDD);
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b1 || bus.rfifo_count !== 5'd1) begin fails++; $display("FAIL nonaligned_next got pd=%b c=%0d exp pd=1 c=1", bus.rfifo_pkt_done, bus.rfifo_count); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin fails++; $display("FAIL nonaligned_read got v=%b d=%h exp v=1 d=5a", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_overflow();
        flush();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i == 14) begin
                tests++; if (bus.rfifo_full !== 1'b0) begin fails++; $display("FAIL ovf_full15 got %b exp 0", bus.rfifo_full); end
            end
        end
        tests++; if (bus.rfifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full16 got %b exp 1", bus.rfifo_full); end
        send_byte(8'hEE);
        tests++; if (bus.rfifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full17 got %b exp 1", bus.rfifo_full); end
        tests++; if (bus.rfifo_ovf !== OVF_EXP) begin fails++; $display("FAIL ovf_flag got %b exp %b", bus.rfifo_ovf, OVF_EXP); end
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b0) begin fails++; $display("FAIL ovf_pkt_done got %b exp 0", bus.rfifo_pkt_done); end
        tests++; if (bus.rfifo_full !== 1'b0 || bus.rfifo_count !== 5'd0) begin fails++; $display("FAIL ovf_rewound got f=%b c=%0d exp f=0 c=0", bus.rfifo_full, bus.rfifo_count); end
        flush();
        tests++; if (bus.rfifo_ovf !== OVF_EXP) begin fails++; $display("FAIL ovf_sticky got %b exp %b", bus.rfifo_ovf, OVF_EXP); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
        commit();
        tests++; if (bus.rfifo_count !== 5'd8) begin fails++; $display("FAIL b2b_count got %0d exp 8", bus.rfifo_count); end
        fork
            begin
                bus.rd_en = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    tick();
                    tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(8'h10 + i)) begin fails++; $display("FAIL b2b_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, 8'(8'h10 + i)); end
                end
                bus.rd_en = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) send_byte(8'(8'h80 + i));
                commit();
                tests++; if (bus.rfifo_pkt_done !== 1'b1) begin fails++; $display("FAIL b2b_pkt2_done got %b exp 1", bus.rfifo_pkt_done); end
            end
        join
        tests++; if (bus.rfifo_count !== 5'd4) begin fails++; $display("FAIL b2b_count2 got %0d exp 4", bus.rfifo_count); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(8'h80 + i)) begin fails++; $display("FAIL b2b_read2_%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, 8'(8'h80 + i)); end
        end
        bus.rd_en = 1'b0;
        tests++; if (bus.rfifo_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b exp 1", bus.rfifo_empty); end
    endtask

    task automatic test_read_commit();
        logic [4:0][7:0] exp = {8'hC2, 8'hC1, 8'hC0, 8'hBB, 8'hAA};
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h01); send_byte(8'h02);
        commit();
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'h03); send_byte(8'h04);
        bus.rd_en = 1'b1;
        bus.rfifo_minuscrc = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.rfifo_minuscrc = 1'b0;
        tests++; if (bus.rfifo_pkt_done !== 1'b1) begin fails++; $display("FAIL rdcmt_pkt_done got %b exp 1", bus.rfifo_pkt_done); end
        tests++; if (bus.rfifo_count !== 5'd4)    begin fails++; $display("FAIL rdcmt_count got %0d exp 4", bus.rfifo_count); end
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hAA) begin fails++; $display("FAIL rdcmt_read got v=%b d=%h exp v=1 d=aa", bus.rd_valid, bus.rd_data); end
        bus.rd_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            tests++; if (bus.rd_data !== exp[i]) begin fails++; $display("FAIL rdcmt_drain%0d got %h exp %h", i, bus.rd_data, exp[i]); end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < 7; j++) send_byte(8'(p * 8 + j));
            commit();
            tests++; if (bus.rfifo_count !== ((p == 0) ? 5'd5 : 5'd10)) begin fails++; $display("FAIL wrap_count_p%0d got %0d exp %0d", p, bus.rfifo_count, (p == 0) ? 5 : 10); end
            if (p > 0) begin
                bus.rd_en = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    tests++; if (bus.rd_data !== 8'((p - 1) * 8 + j)) begin fails++; $display("FAIL wrap_p%0d_b%0d got %h exp %h", p - 1, j, bus.rd_data, 8'((p - 1) * 8 + j)); end
                end
                bus.rd_en = 1'b0;
            end
        end
        bus.rd_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            tests++; if (bus.rd_data !== 8'(72 + j)) begin fails++; $display("FAIL wrap_last_b%0d got %h exp %h", j, bus.rd_data, 8'(72 + j)); end
        end
        bus.rd_en = 1'b0;
        tests++; if (bus.rfifo_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", bus.rfifo_empty); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h00); send_byte(8'h00);
        commit();
        send_bits(12, 32'h0000_0ABC);
        bus.rd_en = 1'b1;
        tick();
        tests++; if (bus.rd_data !== 8'h11) begin fails++; $display("FAIL rstmid_pre_read got %h exp 11", bus.rd_data); end
        rst_sync = 1'b1;
        tick();
        tests++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin fails++; $display("FAIL rstmid_rd got v=%b d=%h exp v=0 d=00", bus.rd_valid, bus.rd_data); end
        tests++; if (bus.rfifo_count !== 5'd0 || bus.rfifo_empty !== 1'b1 || bus.rfifo_full !== 1'b0) begin fails++; $display("FAIL rstmid_flags got c=%0d e=%b f=%b exp c=0 e=1 f=0", bus.rfifo_count, bus.rfifo_empty, bus.rfifo_full); end
        tests++; if (bus.rfifo_ovf !== 1'b0 || bus.rfifo_pkt_done !== 1'b0) begin fails++; $display("FAIL rstmid_ovf_pd got o=%b pd=%b exp 0 0", bus.rfifo_ovf, bus.rfifo_pkt_done); end
        rst_sync = 1'b0;
        bus.rd_en = 1'b0;
        send_byte(8'h66); send_byte(8'h01); send_byte(8'h02);
        commit();
        tests++; if (bus.rfifo_pkt_done !== 1'b1 || bus.rfifo_count !== 5'd1) begin fails++; $display("FAIL rstmid_next got pd=%b c=%0d exp pd=1 c=1", bus.rfifo_pkt_done, bus.rfifo_count); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h66) begin fails++; $display("FAIL rstmid_read got v=%b d=%h exp v=1 d=66", bus.rd_valid, bus.rd_data); end
    endtask

    initial begin
        bus.rfifo_flush0   = 1'b1;
        bus.rfifo_wr       = 1'b0;
        bus.rfifo_bit      = 1'b0;
        bus.rfifo_minuscrc = 1'b0;
        bus.rd_en          = 1'b0;
        test_reset();
        test_basic();
        test_flush();
        test_nonaligned();
        test_overflow();
        test_back_to_back();
        test_read_commit();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1);
    end
endmodule
